// File: rtl/harvos_mem_sched_pkg.sv
// Shared types and constants for the harvos RAM port scheduler.
// State encoding, default master map and default response timeout.
package harvos_pkg;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int MS_DCACHE   = 0;
  localparam int MS_ICACHE   = 1;
  localparam int MS_DBG      = 2;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/harvos_mem_sched_if.sv
// RAM-side command/response bus of the harvos scheduler.
// master = scheduler side, slave = RAM side.
interface harvos_mem_sched_if #(
  parameter int ADDR_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              m_rvalid;
  logic              m_fault;

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_rdata, m_rvalid, m_fault
  );

  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_rvalid, m_fault
  );
endinterface

// File: rtl/harvos_rr_pick.sv
// Rotate-priority picker: first unmasked requester at or after ptr.
// Purely combinational; index and one-hot grant agree.
module harvos_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  input  logic [N-1:0] mask,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx,
  output logic         vld
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!vld && req[j] && !mask[j]) begin
        vld    = 1'b1;
        idx    = j[2:0];
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/harvos_mem_sched.sv
// Round-robin scheduler sharing one RAM port among NUM_M masters.
// Optional grant/stall counters: define HARVOS_MEMSCHED_PERF_EN.
module harvos_mem_sched
  import harvos_pkg::*;
#(
  parameter int NUM_M       = 3,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int ADDR_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_M-1:0]        req,
  input  logic [NUM_M-1:0]        we,
  input  logic [4*NUM_M-1:0]      be,
  input  logic [ADDR_W*NUM_M-1:0] addr,
  input  logic [32*NUM_M-1:0]     wdata,
  output logic [31:0]             rdata,
  output logic [NUM_M-1:0]        rvalid,
  output logic [NUM_M-1:0]        fault,
  output logic [2:0]              grant_id,
  output logic                    busy,
  harvos_mem_sched_if.master      ram,
  output logic                    err_late
`ifdef HARVOS_MEMSCHED_PERF_EN
  ,
  output logic [16*NUM_M-1:0]     perf_grants,
  output logic [16*NUM_M-1:0]     perf_stall
`endif
);
  localparam logic [7:0] TO = 8'(TIMEOUT_CYC);

  state_t           state, nxt;
  logic [2:0]       ptr, gid;
  logic [7:0]       cnt;
  logic [NUM_M-1:0] mask, gid_oh;
  logic             flt;
  logic [NUM_M-1:0] pick_gnt;
  logic [2:0]       pick_idx;
  logic             pick_vld;

  harvos_rr_pick #(.N(NUM_M)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .mask (mask),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign gid_oh      = NUM_M'(1) << gid;
  assign busy        = (state != IDLE);
  assign grant_id    = busy ? gid : 3'd0;
  assign rvalid      = (state == RESP) ? gid_oh : '0;
  assign fault       = rvalid & {NUM_M{flt}};
  assign ram.m_req   = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (pick_vld) nxt = ISSUE;
      ISSUE: nxt = WAIT;
      WAIT:  if (ram.m_rvalid || cnt == TO) nxt = RESP;
      RESP:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= '0;
      gid         <= '0;
      cnt         <= '0;
      mask        <= '0;
      flt         <= 1'b0;
      rdata       <= '0;
      err_late    <= 1'b0;
      ram.m_we    <= 1'b0;
      ram.m_be    <= '0;
      ram.m_addr  <= '0;
      ram.m_wdata <= '0;
    end else begin
      mask <= '0;
      if (ram.m_rvalid && state != WAIT) err_late <= 1'b1;
      unique case (state)
        IDLE: if (pick_vld) begin
          gid         <= pick_idx;
          ram.m_we    <= we[pick_idx];
          ram.m_be    <= be[4*pick_idx +: 4];
          ram.m_addr  <= addr[ADDR_W*pick_idx +: ADDR_W];
          ram.m_wdata <= wdata[32*pick_idx +: 32];
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          // A response in the expiry cycle still carries real data.
          if (ram.m_rvalid) begin
            rdata <= ram.m_rdata;
            flt   <= ram.m_fault;
          end else if (cnt == TO) begin
            rdata <= '0;
            flt   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          ptr  <= (gid == 3'(NUM_M-1)) ? 3'd0 : gid + 3'd1;
          mask <= gid_oh;
        end
        default: ;
      endcase
    end
  end

`ifdef HARVOS_MEMSCHED_PERF_EN
  for (genvar i = 0; i < NUM_M; i++) begin : g_perf
    logic [15:0] gc, sc;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        gc <= '0;
        sc <= '0;
      end else begin
        if (state == ISSUE && gid == 3'(i) && gc != 16'hFFFF)
          gc <= gc + 16'd1;
        if (req[i] && !(busy && gid == 3'(i)) && sc != 16'hFFFF)
          sc <= sc + 16'd1;
      end
    end
    assign perf_grants[16*i +: 16] = gc;
    assign perf_stall[16*i +: 16]  = sc;
  end
`endif
endmodule

// File: tb/tb_harvos_mem_sched.sv
// Directed + randomized bench for harvos_mem_sched.
// RAM responses driven inline; grants predicted by a rotation model.
module tb_harvos_mem_sched;
  localparam int NM = 3;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM-1:0] req, we;
  logic [4*NM-1:0]  be;
  logic [AW*NM-1:0] addr;
  logic [32*NM-1:0] wdata;
  logic [31:0]   rdata;
  logic [NM-1:0] rvalid, fault;
  logic [2:0]    grant_id;
  logic          busy, err_late;

  int n_cmp = 0;
  int n_bad = 0;

  harvos_mem_sched_if #(.ADDR_W(AW)) bus ();

  harvos_mem_sched #(
    .NUM_M(NM), .TIMEOUT_CYC(8), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .fault(fault), .grant_id(grant_id), .busy(busy),
    .ram(bus), .err_late(err_late)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    bus.m_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs one transaction; d = RAM response offset after m_req (0 = never).
  task automatic txn(input int d, input logic [31:0] rd, input logic rf,
                     output int m_at, output int v_at,
                     output logic [2:0] gid, output logic [NM-1:0] rv,
                     output logic [31:0] rdat, output logic [NM-1:0] flt,
                     output logic cwe, output logic [3:0] cbe,
                     output logic [31:0] cad, output logic [31:0] cwd);
    m_at = -1; v_at = -1;
    gid = '0; rv = '0; rdat = '0; flt = '0;
    cwe = 1'b0; cbe = '0; cad = '0; cwd = '0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus.m_rvalid = 1'b0;
      if (bus.m_req && m_at < 0) begin
        m_at = k; gid = grant_id;
        cwe = bus.m_we; cbe = bus.m_be;
        cad = bus.m_addr; cwd = bus.m_wdata;
      end
      if (|rvalid) begin
        v_at = k; rv = rvalid; rdat = rdata; flt = fault;
        break;
      end
      if (m_at > 0 && d > 0 && k == m_at + d) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = rd;
        bus.m_fault  = rf;
      end
    end
    n_cmp++;
    assert (v_at > 0) else begin
      n_bad++;
      $error("FAIL txn_bound got=%0d exp=rvalid", v_at);
    end
  endtask

  initial begin
    int m_at, v_at, d, ptr_m, prev, g, cnt_g[NM];
    logic [2:0] gid;
    logic [NM-1:0] rv, flt, r, seen;
    logic [31:0] rdat, cad, cwd, rd;
    logic cwe, rf;
    logic [3:0] cbe;

    we = '0; be = '0; addr = '0; wdata = '0;
    bus.m_rdata = '0; bus.m_fault = 1'b0;
    do_reset();

    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_fault", 64'(fault), 0);
    chk("rst_rdata", 64'(rdata), 0);
    chk("rst_mreq", 64'(bus.m_req), 0);
    chk("rst_gid", 64'(grant_id), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_errl", 64'(err_late), 0);

    // Single read by master 0.
    addr[31:0] = 32'h0001_0000; we[0] = 1'b0; req = 3'b001;
    txn(2, 32'hDEADBEEF, 1'b0, m_at, v_at, gid, rv, rdat, flt,
        cwe, cbe, cad, cwd);
    req = '0;
    chk("t1_mreq_at", 64'(m_at), 1);
    chk("t1_rv_at", 64'(v_at), 4);
    chk("t1_rv", 64'(rv), 3'b001);
    chk("t1_rdata", 64'(rdat), 32'hDEADBEEF);
    chk("t1_fault", 64'(flt), 0);
    chk("t1_addr", 64'(cad), 32'h0001_0000);
    @(negedge clk);
    chk("t1_pulse", 64'(rvalid), 0);

    // All masters requesting continuously from ptr 0.
    do_reset();
    req = 3'b111;
    for (int i = 0; i < NM; i++) cnt_g[i] = 0;
    for (int n = 0; n < 6; n++) begin
      rd = $urandom;
      rf = 1'($urandom_range(0, 1));
      d  = $urandom_range(1, 8);
      txn(d, rd, rf, m_at, v_at, gid, rv, rdat, flt,
          cwe, cbe, cad, cwd);
      chk("t2_gid", 64'(gid), 64'(n % NM));
      chk("t2_rv", 64'(rv), 64'(1 << (n % NM)));
      chk("t2_rdata", 64'(rdat), 64'(rd));
      chk("t2_fault", 64'(flt), rf ? 64'(1 << (n % NM)) : 0);
      cnt_g[gid]++;
    end
    req = '0;
    for (int i = 0; i < NM; i++) chk("t2_count", 64'(cnt_g[i]), 2);

    // Master 1 partial write.
    do_reset();
    we = 3'b010; be = 12'h030;
    addr[63:32] = 32'h0000_2000; wdata[63:32] = 32'h1234_5678;
    req = 3'b010;
    txn(3, 32'h0, 1'b0, m_at, v_at, gid, rv, rdat, flt,
        cwe, cbe, cad, cwd);
    req = '0; we = '0;
    chk("t3_we", 64'(cwe), 1);
    chk("t3_be", 64'(cbe), 4'b0011);
    chk("t3_wdata", 64'(cwd), 32'h1234_5678);
    chk("t3_addr", 64'(cad), 32'h0000_2000);
    chk("t3_rv", 64'(rv), 3'b010);
    chk("t3_fault", 64'(flt), 0);

    // Timeout, then a late response.
    do_reset();
    req = 3'b001;
    txn(0, 32'h0, 1'b0, m_at, v_at, gid, rv, rdat, flt,
        cwe, cbe, cad, cwd);
    req = '0;
    chk("t4_delay", 64'(v_at - m_at), 10);
    chk("t4_fault", 64'(flt), 3'b001);
    chk("t4_rdata", 64'(rdat), 0);
    chk("t4_errl0", 64'(err_late), 0);
    bus.m_rvalid = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    bus.m_rvalid = 1'b0;
    chk("t4_errl1", 64'(err_late), 1);
    chk("t4_norv", 64'(rvalid), 0);

    // Response in the expiry cycle.
    do_reset();
    req = 3'b100;
    rd = $urandom;
    txn(9, rd, 1'b1, m_at, v_at, gid, rv, rdat, flt,
        cwe, cbe, cad, cwd);
    req = '0;
    chk("t5_delay", 64'(v_at - m_at), 10);
    chk("t5_rdata", 64'(rdat), 64'(rd));
    chk("t5_fault", 64'(flt), 3'b100);
    @(negedge clk);
    chk("t5_errl", 64'(err_late), 0);

    // Reset in WAIT.
    req = 3'b100;
    m_at = -1;
    for (int k = 0; k < 10 && m_at < 0; k++) begin
      @(negedge clk);
      if (bus.m_req) m_at = k;
    end
    chk("t6_issue", 64'(m_at >= 0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_rv", 64'(rvalid), 0);
    rst_n = 1'b1; req = '0;
    seen = '0;
    repeat (12) begin
      @(negedge clk);
      seen |= rvalid;
    end
    chk("t6_quiet", 64'(seen), 0);
    req = 3'b111;
    txn(2, 32'h5A5A_0001, 1'b0, m_at, v_at, gid, rv, rdat, flt,
        cwe, cbe, cad, cwd);
    chk("t6_gid", 64'(gid), 0);
    chk("t6_m_at", 64'(m_at), 1);

    // Random request subsets against the rotation model.
    prev = 0; ptr_m = 1;
    for (int n = 0; n < 24; n++) begin
      r = NM'($urandom_range(1, (1 << NM) - 1));
      for (int i = 0; i < NM; i++) begin
        addr[32*i +: 32]  = $urandom;
        wdata[32*i +: 32] = $urandom;
        be[4*i +: 4]      = 4'($urandom);
        we[i]             = 1'($urandom);
      end
      req = r;
      g = -1;
      for (int k = 0; k < NM; k++)
        if (g < 0 && r[(ptr_m + k) % NM]) g = (ptr_m + k) % NM;
      rd = $urandom;
      rf = 1'($urandom_range(0, 1));
      d  = $urandom_range(1, 9);
      txn(d, rd, rf, m_at, v_at, gid, rv, rdat, flt,
          cwe, cbe, cad, cwd);
      chk("t7_gid", 64'(gid), 64'(g));
      chk("t7_m_at", 64'(m_at), (r == NM'(1 << prev)) ? 3 : 2);
      chk("t7_lat", 64'(v_at - m_at), 64'(d + 1));
      chk("t7_addr", 64'(cad), 64'(addr[32*g +: 32]));
      chk("t7_wdata", 64'(cwd), 64'(wdata[32*g +: 32]));
      chk("t7_be", 64'(cbe), 64'(be[4*g +: 4]));
      chk("t7_we", 64'(cwe), 64'(we[g]));
      chk("t7_rv", 64'(rv), 64'(1 << g));
      chk("t7_rdata", 64'(rdat), 64'(rd));
      chk("t7_fault", 64'(flt), rf ? 64'(1 << g) : 0);
      prev = g;
      ptr_m = (g + 1) % NM;
    end
    req = '0;
    @(negedge clk);
    chk("t7_errl", 64'(err_late), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
